pc_gen: RTL
===========

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning PC and redirect address width.
REQ-002 SHALL have parameter RESET_ADDR, default 32'h0000_0000, meaning PC after reset when set_mode=0.
REQ-003 SHALL have parameter BOOT_ADDR, default `StartAdd, meaning PC after reset when set_mode=1 and the wrap target.
REQ-004 SHALL have parameter END_ADDR, default `INSTADD_END, meaning the last sequential fetch address before wrap.
REQ-005 SHALL have parameter STEP, default 4, meaning the sequential increment, a power of two.
REQ-006 SHALL have port clk, input, 1, meaning the clock.
REQ-007 SHALL have port rst, input, 1, meaning the reset, asynchronous, active-low.
REQ-008 SHALL have port set_mode, input, 1, meaning the reset vector select, sampled while rst=0.
REQ-009 SHALL have port en_i, input, 1, meaning fetch enable.
REQ-010 SHALL have port stall_i, input, 1, meaning a pipeline stall that blocks new requests.
REQ-011 SHALL have port trap_flag_i, input, 1, meaning a trap redirect strobe.
REQ-012 SHALL have port trap_addr_i, input, ADDR_W, meaning the trap target.
REQ-013 SHALL have port branch_flag_i, input, 1, meaning a branch redirect strobe.
REQ-014 SHALL have port branch_addr_i, input, ADDR_W, meaning the branch target.
REQ-015 SHALL have port req_valid_o, output, 1, meaning an instruction fetch request is valid.
REQ-016 SHALL have port req_ready_i, input, 1, meaning the instruction bus accepts the request.
REQ-017 SHALL have port pc_o, output, ADDR_W, meaning the registered fetch address.
REQ-018 SHALL have port ce_o, output, 1, meaning the instruction memory chip enable, equal to req_valid_o.
REQ-019 SHALL have port redir_pend_o, output, 1, meaning a redirect is held, waiting for handshake completion.

Function
REQ-020 SHALL implement a 2-state FSM: IDLE (req_valid_o=0) and REQ (req_valid_o=1).
REQ-021 SHALL transition IDLE->REQ when en_i=1 and stall_i=0, with pc_o unchanged on the transition.
REQ-022 SHALL complete a handshake on any cycle in REQ with req_ready_i=1; on handshake, go to REQ if en_i=1 and stall_i=0, else go to IDLE.
REQ-023 SHALL hold pc_o and req_valid_o stable in REQ while req_ready_i=0, regardless of en_i, stall_i or redirects.
REQ-024 SHALL select the redirect target by priority trap_flag_i over branch_flag_i when both are asserted in the same cycle.
REQ-025 SHALL, on a redirect in IDLE or coinciding with a handshake, load pc_o with the target on the next edge; a held redirect is discarded.
REQ-026 SHALL, on a redirect in REQ with req_ready_i=0, capture the target into the pending register and set redir_pend_o=1.
REQ-027 SHALL let a newer redirect overwrite the pending target.
REQ-028 SHALL, on handshake with redir_pend_o=1, load pc_o with the pending target and clear redir_pend_o.
REQ-029 SHALL, on handshake without any redirect, load pc_o with pc_o+STEP if pc_o<END_ADDR, else BOOT_ADDR.
REQ-030 SHALL perform the increment modulo 2^ADDR_W, and the comparison unsigned.
REQ-031 SHALL force the low log2(STEP) bits of every redirect target to zero before use.
REQ-032 SHALL keep pc_o unchanged in IDLE absent a redirect; en_i=0 does not clear a pending redirect.

Reset
REQ-033 SHALL, while rst=0, asynchronously set pc_o to BOOT_ADDR if set_mode=1, else RESET_ADDR.
REQ-034 SHALL, while rst=0, set the FSM to IDLE, req_valid_o=0, ce_o=0, redir_pend_o=0, and the pending target to 0.
REQ-035 SHALL, on reset asserted mid-request, drop the outstanding request and the pending redirect without a handshake.

Structure
REQ-036 SHALL take `StartAdd, `INSTADD_END, `BranchEnable and `RstEnable from yadan_defs.v; the FSM state encodings shall be added there.
REQ-037 SHALL be a single module; the trap/branch priority mux may be a combinational sub-module pc_redirect_arb.

Verification
REQ-038 SHALL verify: set_mode=1, release rst, en_i=1, req_ready_i=1 -> pc_o = BOOT_ADDR, then +4 each cycle.
REQ-039 SHALL verify: pc_o=END_ADDR with a handshake -> next pc_o=BOOT_ADDR.
REQ-040 SHALL verify: REQ with req_ready_i=0 and branch to 0x100 -> pc_o held and redir_pend_o=1; then ready=1 -> pc_o=0x100 and redir_pend_o=0.
REQ-041 SHALL verify: same-cycle trap 0x200 and branch 0x300 during a handshake -> pc_o=0x200.
REQ-042 SHALL verify: stall_i=1 on a handshake -> IDLE with req_valid_o=0; stall_i=0 -> REQ at the already-advanced pc_o.
REQ-043 SHALL verify: branch to 0x103 -> pc_o=0x100; rst asserted mid-REQ -> req_valid_o=0 immediately.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch PC generator: default address map,
// active levels of the core strobes and the fetch FSM state encoding.
package pc_gen_pkg;

  localparam logic [31:0] START_ADD     = 32'h0000_0000;
  localparam logic [31:0] INSTADD_END   = 32'h0000_FFFC;
  localparam logic        BRANCH_ENABLE = 1'b1;
  localparam logic        RST_ENABLE    = 1'b0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_gen_if.sv
// Instruction fetch request bus between the PC generator (master) and the
// instruction memory / bus (slave).
interface pc_gen_if #(
  parameter int ADDR_W = 32
);

  logic              req_valid_o;
  logic              req_ready_i;
  logic              ce_o;
  logic [ADDR_W-1:0] pc_o;

  modport master (
    output req_valid_o,
    output ce_o,
    output pc_o,
    input  req_ready_i
  );

  modport slave (
    input  req_valid_o,
    input  ce_o,
    input  pc_o,
    output req_ready_i
  );

endinterface

// File: rtl/pc_redirect_arb.sv
// Redirect arbiter: picks the trap target over the branch target and
// clears the sub-step address bits so every redirect lands on a fetch slot.
module pc_redirect_arb
  import pc_gen_pkg::*;
#(
  parameter int          ADDR_W = 32,
  parameter int unsigned STEP   = 4
) (
  input  logic              trap_flag_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  output logic              redir_valid_o,
  output logic [ADDR_W-1:0] redir_addr_o
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(STEP - 1));

  // Trap wins over branch; the chosen target is aligned to STEP.
  always_comb begin
    redir_valid_o = 1'b0;
    redir_addr_o  = '0;
    if (trap_flag_i) begin
      redir_valid_o = 1'b1;
      redir_addr_o  = trap_addr_i & ALIGN_MASK;
    end else if (branch_flag_i == BRANCH_ENABLE) begin
      redir_valid_o = 1'b1;
      redir_addr_o  = branch_addr_i & ALIGN_MASK;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: issues instruction fetch requests with a valid/ready
// handshake, steps sequentially with wrap to BOOT_ADDR past END_ADDR, and
// holds trap/branch redirects that arrive while a request is stalled on the bus.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [ADDR_W-1:0] BOOT_ADDR  = ADDR_W'(START_ADD),
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(INSTADD_END),
  parameter int unsigned       STEP       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_mode,
  input  logic              en_i,
  input  logic              stall_i,
  input  logic              trap_flag_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  output logic              redir_pend_o,
  pc_gen_if.master          bus
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_q, pend_d;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_addr;
  logic [ADDR_W-1:0] seq_addr;
  logic              handshake;
  logic              launch;

  pc_redirect_arb #(
    .ADDR_W (ADDR_W),
    .STEP   (STEP)
  ) u_arb (
    .trap_flag_i   (trap_flag_i),
    .trap_addr_i   (trap_addr_i),
    .branch_flag_i (branch_flag_i),
    .branch_addr_i (branch_addr_i),
    .redir_valid_o (redir_valid),
    .redir_addr_o  (redir_addr)
  );

  assign handshake = (state_q == ST_REQ) && bus.req_ready_i;
  assign launch    = en_i && !stall_i;
  assign seq_addr  = (pc_q < END_ADDR) ? (pc_q + ADDR_W'(STEP)) : BOOT_ADDR;

  // FSM state register; reset drops any outstanding request.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: launch from IDLE, and after each handshake decide whether to keep requesting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (launch) state_d = ST_REQ;
      ST_REQ:  if (handshake) state_d = launch ? ST_REQ : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: the request is valid exactly in REQ, and the memory enable follows it.
  always_comb begin
    bus.req_valid_o = 1'b0;
    bus.ce_o        = 1'b0;
    if (state_q == ST_REQ) begin
      bus.req_valid_o = 1'b1;
      bus.ce_o        = 1'b1;
    end
  end

  // Next PC and pending redirect: the address on the bus never moves while a request waits.
  always_comb begin
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    if (state_q == ST_IDLE) begin
      if (redir_valid) pc_d = redir_addr;
    end else if (handshake) begin
      pend_d = 1'b0;
      if (redir_valid) begin
        pc_d = redir_addr;
      end else if (pend_q) begin
        pc_d = pend_addr_q;
      end else begin
        pc_d = seq_addr;
      end
    end else if (redir_valid) begin
      pend_d      = 1'b1;
      pend_addr_d = redir_addr;
    end
  end

  // PC and pending-redirect registers; the reset vector is chosen by set_mode.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      pc_q        <= set_mode ? BOOT_ADDR : RESET_ADDR;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign bus.pc_o     = pc_q;
  assign redir_pend_o = pend_q;

endmodule
